mem_align_unit: RTL and testbench
=================================

# mem_align_unit

Parametrised load/store alignment engine between the MEM stage and the data-memory bus. It accepts one access per request: byte, half, word, and on 64-bit builds doubleword. It drives a word-aligned bus with byte strobes, shifts store data into lane position, and extracts and sign- or zero-extends load data. Accesses that cross a bus word either raise an address-alignment error (ALE) or are split into two bus beats, selected by parameter.

## Interface
- `DATA_W`, default 32: bus and register width. Legal values are 32 and 64. `BYTES = DATA_W/8`; `OFS_W = log2(BYTES)`.
- `ALLOW_MISALIGN`, default 0:
  - 0: any access not naturally aligned is rejected with ALE.
  - 1: word-crossing accesses are split into two beats; non-crossing misaligned accesses complete in one beat.
- `cpu_clk` input 1: clock. All state changes on the rising edge.
- `cpu_rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit can accept a request. High only in IDLE.
- `req_we` input 1: 1 = store, 0 = load.
- `req_op` input 3: access size and extension.
  - 000 B, 001 BU, 010 H, 011 HU, 100 W, 101 WU, 110 D.
  - On DATA_W=32, WU, D and 111 behave as W. On DATA_W=64, 111 behaves as D.
  - Extension bits are ignored for stores.
- `req_addr` input 32: byte address.
- `req_wdata` input DATA_W: store data, right-justified.
- `bus_req` output 1: bus beat request.
- `bus_ack` input 1: beat complete. `bus_rdata` is valid in the same cycle.
- `bus_we` output 1: beat is a write.
- `bus_addr` output 32: beat address, always BYTES-aligned.
- `bus_wstrb` output BYTES: byte enables.
- `bus_wdata` output DATA_W: lane-positioned store data.
- `bus_rdata` input DATA_W: read data.
- `rsp_valid` output 1: one-cycle completion pulse. There is no backpressure.
- `rsp_rdata` output DATA_W: extended load result. 0 for stores and for ALE.
- `rsp_ale` output 1: alignment error. Qualified by `rsp_valid`.

## Operation
- **Reset values:** state IDLE; `req_ready` 1; `bus_req`, `bus_we`, `rsp_valid`, `rsp_ale` 0; `bus_addr`, `bus_wstrb`, `bus_wdata`, `rsp_rdata` 0.
- **Accept:** when `req_valid & req_ready`, register `op`, `we`, `addr`, `wdata`.
  - `size` = 1/2/4/8 bytes; `ofs` = `addr[OFS_W-1:0]`.
  - `cross` = `ofs + size > BYTES`.
  - `misal` = `addr mod size != 0`.
- **States:** IDLE, BEAT0, BEAT1, RESP.
  - IDLE → RESP when accepted and ALE applies: `misal & !ALLOW_MISALIGN`. No bus beat is issued.
  - IDLE → BEAT0 otherwise on accept.
  - BEAT0 → BEAT1 on `bus_ack` when `cross`; else BEAT0 → RESP on `bus_ack`.
  - BEAT1 → RESP on `bus_ack`.
  - RESP → IDLE unconditionally.
- **Beat addressing:** BEAT0 address = `addr` with its low OFS_W bits cleared. BEAT1 address = BEAT0 address + BYTES (32-bit wrap).
- **Store lanes:** form a 2·DATA_W vector `wdata << (8·ofs)` and 2·BYTES strobe `((1<<size)-1) << ofs`. BEAT0 drives the low halves, BEAT1 the high halves. Bytes outside the strobe are driven 0.
- **Load assembly:**
  - BEAT0 `bus_rdata` is captured into `lo`; BEAT1 `bus_rdata` into `hi`. When there is no BEAT1, `hi` = 0.
  - `raw = ({hi, lo} >> (8·ofs))[DATA_W-1:0]`, truncated to `size`.
  - Signed ops (B, H, W) sign-extend from the top byte of `size`. Unsigned ops (BU, HU, WU) zero-extend. D and 32-bit W pass through.
- **Bus hold:** `bus_req`, `bus_addr`, `bus_we`, `bus_wstrb`, `bus_wdata` are held stable from beat start until the `bus_ack` cycle inclusive. `bus_req` deasserts in the cycle after the ack of the last beat. Between beats of a split access, `bus_req` stays high and the beat fields change on that edge.
- **Ignored inputs:** `bus_ack` while `bus_req` = 0 is ignored. `req_*` changes outside the accept cycle are ignored.

## Timing
- Accept at edge T → BEAT0 `bus_req` high in cycle T+1.
- Single beat, ack in cycle T+k → `rsp_valid` in cycle T+k+1.
- Split access, ack in BEAT0 at cycle T+k and BEAT1 `bus_req` high from T+k+1:
  - BEAT1 ack at cycle T+m → `rsp_valid` in cycle T+m+1.
  - Minimum latency, acceptance to `rsp_valid`, is 3 cycles.
- ALE: `rsp_valid`/`rsp_ale` in cycle T+1 and no bus activity.
- `req_ready` is low from T+1 through the RESP cycle; it returns high the cycle after RESP. Back-to-back throughput is one access per (beats + 2) cycles.
- Reset mid-operation:
  - Next edge returns to IDLE, and `bus_req` is 0 in the following cycle.
  - The pending access produces no `rsp_valid`; captured `lo`/`hi` are discarded.
  - An ack arriving in the reset cycle is ignored.

## Test plan
All scenarios use DATA_W=32.
1. **Sub-word loads:** load B at 0x103 with `bus_rdata` 0x80FF_1234 → `bus_addr` 0x100, `rsp_rdata` 0xFFFF_FF80. Load BU at the same address → 0x0000_0080. Load H at 0x102 with 0x8001_ABCD → 0xFFFF_8001.
2. **Sub-word store:** H store at 0x102, ALLOW_MISALIGN=0, `wdata` 0x0000_BEEF → one beat with `bus_wstrb` 4'b1100 and `bus_wdata` 0xBEEF_0000. Then `rsp_valid` with `rsp_ale` 0 and `rsp_rdata` 0.
3. **ALE path:** ALLOW_MISALIGN=0, W load at 0x102 → `bus_req` never asserted. `rsp_valid` and `rsp_ale` = 1 in cycle T+1, `rsp_rdata` 0.
4. **Split load:** ALLOW_MISALIGN=1, W load at 0x102.
   - Beat 0x100 returns 0x4433_2211; beat 0x104 returns 0x8877_6655.
   - Result: `rsp_rdata` 0x6655_4433, and `rsp_valid` exactly once.
   - Also H load at 0x101 → single beat, result from bytes 1–2.
5. **Split store:** ALLOW_MISALIGN=1, W store at 0x103 with `wdata` 0xAABB_CCDD.
   - Beat 0x100: strobe 4'b1000, `bus_wdata` 0xDD00_0000.
   - Beat 0x104: strobe 4'b0111, `bus_wdata` 0x00AA_BBCC.
   - Ack delayed 3 cycles per beat; fields must stay stable throughout.
6. **Reset mid-access:** assert `cpu_rst` during BEAT1 of scenario 4 with ack withheld → `bus_req` 0 the next cycle, no `rsp_valid`, `req_ready` 1. A fresh B load at 0x100 then completes normally.

Source files
------------

// File: rtl/mem_align_unit.sv
// rtl/mem_align_unit.sv - load/store alignment engine between MEM stage and data bus
//
// Ports:
//   cpu_clk, cpu_rst               clock, synchronous active-high reset
//   req_valid/req_ready            request handshake (ready only while idle)
//   req_we, req_op, req_addr,
//   req_wdata                      access kind, size/extension, byte address, store data
//   bus_req/bus_ack                bus beat request / completion
//   bus_we, bus_addr, bus_wstrb,
//   bus_wdata, bus_rdata           word-aligned beat fields and read data
//   rsp_valid, rsp_rdata, rsp_ale  one-cycle completion, extended load data, alignment error
module mem_align_unit #(
    parameter int DATA_W         = 32,
    parameter bit ALLOW_MISALIGN = 1'b0
) (
    input  logic                cpu_clk,
    input  logic                cpu_rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_op,
    input  logic [31:0]         req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                bus_req,
    input  logic                bus_ack,
    output logic                bus_we,
    output logic [31:0]         bus_addr,
    output logic [DATA_W/8-1:0] bus_wstrb,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_ale
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFS_W = $clog2(BYTES);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
    state_t state;

    logic [3:0]        size_q;
    logic              signed_q;
    logic              cross_q;
    logic              we_q;
    logic [OFS_W-1:0]  ofs_q;
    logic [DATA_W-1:0] lo_q;
    logic [BYTES-1:0]  hi_strb_q;
    logic [DATA_W-1:0] hi_wdata_q;

    // Decode of the incoming request, used only in the accept cycle.
    logic [3:0]          a_size;
    logic [OFS_W-1:0]    a_ofs;
    logic                a_misal;
    logic                a_cross;
    logic [2*BYTES-1:0]  a_strb;
    logic [2*DATA_W-1:0] a_data;

    always_comb begin
        case (req_op[2:1])
            2'b00:   a_size = 4'd1;
            2'b01:   a_size = 4'd2;
            2'b10:   a_size = 4'd4;
            default: a_size = (DATA_W == 64) ? 4'd8 : 4'd4;
        endcase
        a_ofs   = req_addr[OFS_W-1:0];
        a_misal = (req_addr[3:0] & (a_size - 4'd1)) != 4'd0;
        a_cross = (5'(a_ofs) + 5'(a_size)) > 5'(BYTES);
        a_data  = {{DATA_W{1'b0}}, req_wdata} << {a_ofs, 3'b000};
        for (int i = 0; i < 2 * BYTES; i++) begin
            a_strb[i] = (i >= int'(a_ofs)) && (i < int'(a_ofs) + int'(a_size));
            // Bytes outside the access (and all bytes of a load) are driven as zero.
            if (!a_strb[i] || !req_we) begin
                a_data[8*i +: 8] = 8'h00;
            end
        end
    end

    // Load extraction: the second beat (if any) supplies the high word.
    logic [2*DATA_W-1:0] l_pair;
    logic [DATA_W-1:0]   l_shift;
    logic [DATA_W-1:0]   l_result;
    logic                l_sign;

    always_comb begin
        l_pair  = (state == BEAT1) ? {bus_rdata, lo_q} : {{DATA_W{1'b0}}, bus_rdata};
        l_shift = DATA_W'(l_pair >> {ofs_q, 3'b000});
        case (size_q)
            4'd1:    l_sign = l_shift[7];
            4'd2:    l_sign = l_shift[15];
            4'd4:    l_sign = l_shift[31];
            default: l_sign = 1'b0;
        endcase
        for (int i = 0; i < BYTES; i++) begin
            l_result[8*i +: 8] = (i < int'(size_q)) ? l_shift[8*i +: 8]
                                                    : {8{signed_q & l_sign}};
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wstrb  <= '0;
            bus_wdata  <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_ale    <= 1'b0;
            size_q     <= '0;
            signed_q   <= 1'b0;
            cross_q    <= 1'b0;
            we_q       <= 1'b0;
            ofs_q      <= '0;
            lo_q       <= '0;
            hi_strb_q  <= '0;
            hi_wdata_q <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        size_q    <= a_size;
                        signed_q  <= ~req_op[0];
                        cross_q   <= a_cross;
                        we_q      <= req_we;
                        ofs_q     <= a_ofs;
                        if (a_misal && !ALLOW_MISALIGN) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_ale   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state      <= BEAT0;
                            bus_req    <= 1'b1;
                            bus_we     <= req_we;
                            bus_addr   <= req_addr & ~32'(BYTES - 1);
                            bus_wstrb  <= a_strb[BYTES-1:0];
                            bus_wdata  <= a_data[DATA_W-1:0];
                            hi_strb_q  <= a_strb[2*BYTES-1:BYTES];
                            hi_wdata_q <= a_data[2*DATA_W-1:DATA_W];
                        end
                    end
                end
                BEAT0: begin
                    if (bus_ack) begin
                        lo_q <= bus_rdata;
                        if (cross_q) begin
                            state     <= BEAT1;
                            bus_addr  <= bus_addr + 32'(BYTES);
                            bus_wstrb <= hi_strb_q;
                            bus_wdata <= hi_wdata_q;
                        end else begin
                            state     <= RESP;
                            bus_req   <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_ale   <= 1'b0;
                            rsp_rdata <= we_q ? '0 : l_result;
                        end
                    end
                end
                BEAT1: begin
                    if (bus_ack) begin
                        state     <= RESP;
                        bus_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_ale   <= 1'b0;
                        rsp_rdata <= we_q ? '0 : l_result;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_ale   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_align_unit.sv
// tb/tb_mem_align_unit.sv - self-checking bench for mem_align_unit (strict and split instances)
module tb_mem_align_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [2:0]  req_op    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        bus_req   [2];
    logic        bus_ack   [2];
    logic        bus_we    [2];
    logic [31:0] bus_addr  [2];
    logic [3:0]  bus_wstrb [2];
    logic [31:0] bus_wdata [2];
    logic [31:0] bus_rdata [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_ale   [2];

    // Instance 0 rejects misaligned accesses, instance 1 splits them.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_align_unit #(.DATA_W(32), .ALLOW_MISALIGN(g == 1)) u_dut (
            .cpu_clk  (clk),
            .cpu_rst  (rst),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_we   (req_we[g]),
            .req_op   (req_op[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .bus_req  (bus_req[g]),
            .bus_ack  (bus_ack[g]),
            .bus_we   (bus_we[g]),
            .bus_addr (bus_addr[g]),
            .bus_wstrb(bus_wstrb[g]),
            .bus_wdata(bus_wdata[g]),
            .bus_rdata(bus_rdata[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_ale  (rsp_ale[g])
        );
    end

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } beat_t;

    beat_t      beats[$];
    logic [7:0] mem     [2][256];
    logic [7:0] ref_mem [2][256];
    int         ack_delay [2];
    int         ack_limit [2];
    int         acked     [2];
    int         rsp_cnt   [2];
    int         n_pass  = 0;
    int         n_total = 0;

    function automatic int op_size(input logic [2:0] op);
        if (op[2:1] == 2'b00) return 1;
        if (op[2:1] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input int sel, input logic [2:0] op, input logic [31:0] addr);
        int     size = op_size(op);
        longint v    = 0;
        for (int i = 0; i < size; i++)
            v = v | (longint'(ref_mem[sel][(int'(addr[7:0]) + i) % 256]) << (8 * i));
        if (size < 4 && !op[0] && v >= (longint'(1) << (8 * size - 1)))
            v = v - (longint'(1) << (8 * size));
        return v[31:0];
    endfunction

    task automatic ref_store(input int sel, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        for (int i = 0; i < op_size(op); i++)
            ref_mem[sel][(int'(addr[7:0]) + i) % 256] = 8'(wdata >> (8 * i));
    endtask

    // Bus slave for both instances: memory-backed, programmable ack delay,
    // checks that beat fields stay stable until acked, counts responses.
    task automatic responder();
        int          wait_cnt [2] = '{0, 0};
        logic [31:0] s_addr  [2];
        logic        s_we    [2];
        logic [3:0]  s_strb  [2];
        logic [31:0] s_wdata [2];
        logic [31:0] rd;
        int          idx;
        forever begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                if (rsp_valid[s]) rsp_cnt[s]++;
                bus_ack[s]   = 1'b0;
                bus_rdata[s] = $urandom;
                if (!bus_req[s]) begin
                    wait_cnt[s] = 0;
                end else begin
                    if (wait_cnt[s] == 0) begin
                        s_addr[s] = bus_addr[s]; s_we[s] = bus_we[s];
                        s_strb[s] = bus_wstrb[s]; s_wdata[s] = bus_wdata[s];
                    end else begin
                        n_total++;
                        if ({bus_addr[s], bus_we[s], bus_wstrb[s], bus_wdata[s]} !==
                            {s_addr[s], s_we[s], s_strb[s], s_wdata[s]})
                            $display("FAIL bus_hold[%0d]: got addr=%h we=%b strb=%b wdata=%h required addr=%h we=%b strb=%b wdata=%h",
                                     s, bus_addr[s], bus_we[s], bus_wstrb[s], bus_wdata[s],
                                     s_addr[s], s_we[s], s_strb[s], s_wdata[s]);
                        else n_pass++;
                    end
                    if (acked[s] < ack_limit[s] && wait_cnt[s] >= ack_delay[s]) begin
                        for (int i = 0; i < 4; i++) begin
                            idx = (int'(bus_addr[s][7:0]) + i) % 256;
                            rd[8*i +: 8] = mem[s][idx];
                            if (bus_we[s] && bus_wstrb[s][i]) mem[s][idx] = bus_wdata[s][8*i +: 8];
                        end
                        bus_rdata[s] = rd;
                        bus_ack[s]   = 1'b1;
                        beats.push_back('{bus_addr[s], bus_we[s], bus_wstrb[s], bus_wdata[s]});
                        acked[s]++;
                        wait_cnt[s] = 0;
                    end else begin
                        wait_cnt[s]++;
                    end
                end
            end
        end
    endtask

    task automatic do_access(input int sel, input logic we, input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rdata, output logic ale,
                             output int lat, output int t_acc);
        int guard = 0;
        rdata = '0; ale = 1'b0; lat = 0; t_acc = 0;
        @(negedge clk);
        while (!req_ready[sel] && guard < 100) begin @(negedge clk); guard++; end
        if (!req_ready[sel]) begin
            n_total++;
            $display("FAIL ready_wait[%0d]: req_ready=%b required 1", sel, req_ready[sel]);
            lat = -1;
            return;
        end
        req_valid[sel] = 1'b1; req_we[sel] = we; req_op[sel] = op;
        req_addr[sel] = addr; req_wdata[sel] = wdata;
        @(posedge clk);
        t_acc = int'($time);
        #1;
        req_valid[sel] = 1'b0; req_we[sel] = $urandom; req_op[sel] = 3'($urandom);
        req_addr[sel] = $urandom; req_wdata[sel] = $urandom;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (rsp_valid[sel]) break;
        end
        if (!rsp_valid[sel]) begin
            n_total++;
            $display("FAIL rsp_timeout[%0d]: rsp_valid=0 required 1 within 100 cycles", sel);
            lat = -1;
        end else begin
            rdata = rsp_rdata[sel];
            ale   = rsp_ale[sel];
        end
    endtask

    task automatic preload(input int sel, input logic [31:0] addr, input logic [31:0] word);
        for (int i = 0; i < 4; i++) begin
            mem[sel][(int'(addr[7:0]) + i) % 256]     = word[8*i +: 8];
            ref_mem[sel][(int'(addr[7:0]) + i) % 256] = word[8*i +: 8];
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            n_total++;
            if ({req_ready[s], bus_req[s], bus_we[s], rsp_valid[s], rsp_ale[s]} !== 5'b10000)
                $display("FAIL reset_ctrl[%0d]: got ready,req,we,valid,ale=%b%b%b%b%b required 10000",
                         s, req_ready[s], bus_req[s], bus_we[s], rsp_valid[s], rsp_ale[s]);
            else n_pass++;
            n_total++;
            if ({bus_addr[s], bus_wstrb[s], bus_wdata[s], rsp_rdata[s]} !== 100'd0)
                $display("FAIL reset_data[%0d]: got addr=%h strb=%b wdata=%h rdata=%h required all 0",
                         s, bus_addr[s], bus_wstrb[s], bus_wdata[s], rsp_rdata[s]);
            else n_pass++;
        end
    endtask

    task automatic test_subword_load();
        logic [31:0] rd; logic ale; int lat, t, nb;
        logic [31:0] exp_v [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001};
        logic [2:0]  ops   [3] = '{3'b000, 3'b001, 3'b010};
        logic [31:0] adrs  [3] = '{32'h103, 32'h103, 32'h102};
        logic [31:0] words [3] = '{32'h80FF_1234, 32'h80FF_1234, 32'h8001_ABCD};
        ack_delay[0] = 1;
        for (int k = 0; k < 3; k++) begin
            preload(0, 32'h100, words[k]);
            nb = beats.size();
            do_access(0, 1'b0, ops[k], adrs[k], 32'h0, rd, ale, lat, t);
            n_total++;
            if (rd !== exp_v[k] || ale !== 1'b0)
                $display("FAIL subword_load%0d: got rdata=%h ale=%b required rdata=%h ale=0", k, rd, ale, exp_v[k]);
            else n_pass++;
            n_total++;
            if (beats.size() - nb != 1 || beats[beats.size()-1].addr !== 32'h100)
                $display("FAIL subword_load_addr%0d: got %0d beats last addr=%h required 1 beat at 00000100",
                         k, beats.size() - nb, beats[beats.size()-1].addr);
            else n_pass++;
        end
    endtask

    task automatic test_subword_store();
        logic [31:0] rd; logic ale; int lat, t, nb;
        ack_delay[0] = 0;
        nb = beats.size();
        do_access(0, 1'b1, 3'b010, 32'h102, 32'h0000_BEEF, rd, ale, lat, t);
        ref_store(0, 3'b010, 32'h102, 32'h0000_BEEF);
        n_total++;
        if (beats.size() - nb != 1 || beats[nb].strb !== 4'b1100 || beats[nb].wdata !== 32'hBEEF_0000 ||
            beats[nb].we !== 1'b1 || beats[nb].addr !== 32'h100)
            $display("FAIL subword_store_beat: got %0d beats strb=%b wdata=%h we=%b addr=%h required 1 beat strb=1100 wdata=beef0000 we=1 addr=00000100",
                     beats.size() - nb, beats[nb].strb, beats[nb].wdata, beats[nb].we, beats[nb].addr);
        else n_pass++;
        n_total++;
        if (rd !== 32'h0 || ale !== 1'b0)
            $display("FAIL subword_store_rsp: got rdata=%h ale=%b required 0/0", rd, ale);
        else n_pass++;
    endtask

    task automatic test_ale();
        logic [31:0] rd; logic ale; int lat, t, nb;
        nb = beats.size();
        do_access(0, 1'b0, 3'b100, 32'h102, 32'h0, rd, ale, lat, t);
        n_total++;
        if (ale !== 1'b1 || rd !== 32'h0 || lat != 1)
            $display("FAIL ale_rsp: got ale=%b rdata=%h latency=%0d required ale=1 rdata=0 latency=1", ale, rd, lat);
        else n_pass++;
        n_total++;
        if (beats.size() != nb)
            $display("FAIL ale_no_bus: got %0d beats required 0", beats.size() - nb);
        else n_pass++;
    endtask

    task automatic test_split_load();
        logic [31:0] rd; logic ale; int lat, t, nb, c0;
        ack_delay[1] = 0;
        preload(1, 32'h100, 32'h4433_2211);
        preload(1, 32'h104, 32'h8877_6655);
        nb = beats.size();
        c0 = rsp_cnt[1];
        do_access(1, 1'b0, 3'b100, 32'h102, 32'h0, rd, ale, lat, t);
        repeat (4) @(negedge clk);
        n_total++;
        if (rd !== 32'h6655_4433 || ale !== 1'b0 || lat != 3)
            $display("FAIL split_load: got rdata=%h ale=%b latency=%0d required 66554433/0/3", rd, ale, lat);
        else n_pass++;
        n_total++;
        if (beats.size() - nb != 2 || beats[nb].addr !== 32'h100 || beats[nb+1].addr !== 32'h104)
            $display("FAIL split_load_beats: got %0d beats addrs %h,%h required 2 at 00000100,00000104",
                     beats.size() - nb, beats[nb].addr, beats[nb+1].addr);
        else n_pass++;
        n_total++;
        if (rsp_cnt[1] - c0 != 1)
            $display("FAIL split_load_once: got %0d rsp_valid pulses required 1", rsp_cnt[1] - c0);
        else n_pass++;
        nb = beats.size();
        do_access(1, 1'b0, 3'b010, 32'h101, 32'h0, rd, ale, lat, t);
        n_total++;
        if (rd !== 32'h0000_3322 || beats.size() - nb != 1)
            $display("FAIL half_in_word: got rdata=%h beats=%0d required 00003322 with 1 beat", rd, beats.size() - nb);
        else n_pass++;
    endtask

    task automatic test_split_store();
        logic [31:0] rd; logic ale; int lat, t, nb;
        ack_delay[1] = 3;
        nb = beats.size();
        do_access(1, 1'b1, 3'b100, 32'h103, 32'hAABB_CCDD, rd, ale, lat, t);
        ref_store(1, 3'b100, 32'h103, 32'hAABB_CCDD);
        n_total++;
        if (beats.size() - nb != 2 ||
            {beats[nb].addr, beats[nb].strb, beats[nb].wdata} !== {32'h100, 4'b1000, 32'hDD00_0000} ||
            {beats[nb+1].addr, beats[nb+1].strb, beats[nb+1].wdata} !== {32'h104, 4'b0111, 32'h00AA_BBCC})
            $display("FAIL split_store_beats: got %0d beats b0=%h/%b/%h b1=%h/%b/%h required 00000100/1000/dd000000 00000104/0111/00aabbcc",
                     beats.size() - nb, beats[nb].addr, beats[nb].strb, beats[nb].wdata,
                     beats[nb+1].addr, beats[nb+1].strb, beats[nb+1].wdata);
        else n_pass++;
        n_total++;
        if (lat != 9 || ale !== 1'b0 || rd !== 32'h0)
            $display("FAIL split_store_rsp: got latency=%0d ale=%b rdata=%h required 9/0/0", lat, ale, rd);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic ale; int lat, t, guard, c0;
        ack_delay[1] = 0;
        ack_limit[1] = acked[1] + 1;
        c0 = rsp_cnt[1];
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_op[1] = 3'b100; req_addr[1] = 32'h102;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!(bus_req[1] && bus_addr[1] == 32'h104) && guard < 20) begin @(negedge clk); guard++; end
        n_total++;
        if (!(bus_req[1] && bus_addr[1] == 32'h104))
            $display("FAIL reset_mid_beat1: got req=%b addr=%h required 1/00000104", bus_req[1], bus_addr[1]);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++;
        if ({bus_req[1], req_ready[1], rsp_valid[1]} !== 3'b010)
            $display("FAIL reset_mid_state: got req,ready,valid=%b%b%b required 010", bus_req[1], req_ready[1], rsp_valid[1]);
        else n_pass++;
        repeat (5) @(negedge clk);
        n_total++;
        if (rsp_cnt[1] != c0 || bus_req[1] !== 1'b0)
            $display("FAIL reset_mid_quiet: got %0d rsp pulses req=%b required 0/0", rsp_cnt[1] - c0, bus_req[1]);
        else n_pass++;
        ack_limit[1] = 1 << 30;
        do_access(1, 1'b0, 3'b000, 32'h100, 32'h0, rd, ale, lat, t);
        n_total++;
        if (rd !== ref_load(1, 3'b000, 32'h100) || ale !== 1'b0 || lat != 2)
            $display("FAIL reset_mid_fresh: got rdata=%h ale=%b latency=%0d required %h/0/2",
                     rd, ale, lat, ref_load(1, 3'b000, 32'h100));
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic ale; int lat, t, t_prev;
        ack_delay[0] = 0;
        for (int k = 0; k < 4; k++) begin
            do_access(0, 1'b0, 3'b000, 32'h110 + 32'(k), 32'h0, rd, ale, lat, t);
            if (k > 0) begin
                n_total++;
                if (t - t_prev != 30)
                    $display("FAIL back_to_back%0d: got %0d cycles between accepts required 3", k, (t - t_prev) / 10);
                else n_pass++;
            end
            t_prev = t;
        end
    endtask

    task automatic test_random(input int sel, input int n);
        logic [31:0] rd, addr, wdata, exp_rd; logic ale, we, exp_ale; logic [2:0] op;
        int lat, t, nb, d, size, exp_beats, bad;
        for (int k = 0; k < n; k++) begin
            we = 1'($urandom); op = 3'($urandom_range(0, 7));
            addr = 32'h100 + 32'($urandom_range(0, 239)); wdata = $urandom;
            d = $urandom_range(0, 2);
            ack_delay[sel] = d;
            size = op_size(op);
            exp_ale   = (sel == 0) && (int'(addr[1:0]) % size != 0);
            exp_beats = exp_ale ? 0 : ((int'(addr[1:0]) + size > 4) ? 2 : 1);
            exp_rd    = (we || exp_ale) ? 32'h0 : ref_load(sel, op, addr);
            if (we && !exp_ale) ref_store(sel, op, addr, wdata);
            nb = beats.size();
            do_access(sel, we, op, addr, wdata, rd, ale, lat, t);
            n_total++;
            if (rd !== exp_rd || ale !== exp_ale)
                $display("FAIL rand%0d_%0d rsp (we=%b op=%b addr=%h): got rdata=%h ale=%b required %h/%b",
                         sel, k, we, op, addr, rd, ale, exp_rd, exp_ale);
            else n_pass++;
            n_total++;
            if (beats.size() - nb != exp_beats || lat != (exp_ale ? 1 : exp_beats * (d + 1) + 1))
                $display("FAIL rand%0d_%0d timing: got beats=%0d latency=%0d required %0d/%0d",
                         sel, k, beats.size() - nb, lat, exp_beats, exp_ale ? 1 : exp_beats * (d + 1) + 1);
            else n_pass++;
            if (we) begin
                bad = 0;
                for (int i = -4; i < 9; i++)
                    if (mem[sel][(int'(addr[7:0]) + i + 256) % 256] !== ref_mem[sel][(int'(addr[7:0]) + i + 256) % 256])
                        bad++;
                n_total++;
                if (bad != 0)
                    $display("FAIL rand%0d_%0d mem (op=%b addr=%h wdata=%h): got %0d wrong bytes required 0",
                             sel, k, op, addr, wdata, bad);
                else n_pass++;
            end
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0; req_we[s] = 1'b0; req_op[s] = 3'b0;
            req_addr[s] = '0; req_wdata[s] = '0;
            bus_ack[s] = 1'b0; bus_rdata[s] = '0;
            ack_delay[s] = 0; ack_limit[s] = 1 << 30; acked[s] = 0; rsp_cnt[s] = 0;
            for (int i = 0; i < 256; i++) begin
                mem[s][i] = 8'($urandom);
                ref_mem[s][i] = mem[s][i];
            end
        end
        fork
            responder();
        join_none
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_subword_load();
        test_subword_store();
        test_ale();
        test_split_load();
        test_split_store();
        test_reset_mid();
        test_back_to_back();
        test_random(0, 60);
        test_random(1, 60);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
